ssm_io_sequencer: RTL

SSM_IO_SEQUENCER -- requirements
Module: ssm_io_sequencer

---
 rtl/ssm_io_pkg.sv | 5 +
 rtl/ssm_word_serializer.sv | 40 ++++
 rtl/ssm_io_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/ssm_io_pkg.sv
// ssm_io_pkg: shared segment and FSM encodings for the SSM I/O sequencer
package ssm_io_pkg;
    typedef enum logic [2:0] {SEG_DT, SEG_DA, SEG_BM, SEG_C, SEG_D, SEG_X, SEG_H} seg_t;
    typedef enum logic [1:0] {LOAD, FIRE, WAIT, DRAIN} state_t;
endpackage

// File: rtl/ssm_word_serializer.sv
// ssm_word_serializer: captures a flat result vector and streams it out one word per handshake
module ssm_word_serializer #(
    parameter int WORDS = 16,
    parameter int DW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [WORDS*DW-1:0] y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic                out_last,
    output logic                done
);
    localparam int KW = WORDS > 1 ? $clog2(WORDS) : 1;
    logic [WORDS*DW-1:0] y;
    logic [KW-1:0]       k;
    logic                active;
    always_ff @(posedge clk) begin
        if (rst) begin
            y      <= '0;
            k      <= '0;
            active <= 1'b0;
        end else if (load) begin
            y      <= y_in;
            k      <= '0;
            active <= 1'b1;
        end else if (done) begin
            k      <= '0;
            active <= 1'b0;
        end else if (out_valid && out_ready) begin
            k <= k + 1'b1;
        end
    end
    assign out_valid = active;
    assign out_last  = active && (k == KW'(WORDS - 1));
    assign out_data  = active ? y[DW*k +: DW] : '0;
    assign done      = out_valid & out_ready & out_last;
endmodule

// File: rtl/ssm_io_sequencer.sv
// ssm_io_sequencer: loads a segmented operand frame, fires the SSM core, and streams its result back
module ssm_io_sequencer import ssm_io_pkg::*; #(
    parameter int B  = 1,
    parameter int H  = 4,
    parameter int P  = 4,
    parameter int N  = 4,
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    input  logic                  keep_state,
    output logic [B*H*DW-1:0]     dt_flat,
    output logic [B*H*DW-1:0]     dA_flat,
    output logic [B*N*DW-1:0]     Bmat_flat,
    output logic [B*N*DW-1:0]     C_flat,
    output logic [H*DW-1:0]       D_flat,
    output logic [B*H*P*DW-1:0]   x_flat,
    output logic [B*H*P*N*DW-1:0] h_prev_flat,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [B*H*P*DW-1:0]   core_y_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic                  out_last,
    output logic                  busy
);
    localparam int IW = $clog2(B*H*P*N + 1);
    state_t        state, state_n;
    seg_t          seg;
    logic [IW-1:0] idx, seg_len;
    logic          keep_q, accept, seg_end, frame_end, capture, drain_done;
    always_comb begin
        seg_len   = (seg == SEG_DT || seg == SEG_DA) ? IW'(B*H) :
                    (seg == SEG_BM || seg == SEG_C)  ? IW'(B*N) :
                    (seg == SEG_D)                   ? IW'(H)   :
                    (seg == SEG_X)                   ? IW'(B*H*P) : IW'(B*H*P*N);
        accept    = in_valid & in_ready;
        seg_end   = idx == seg_len - 1'b1;
        // With keep_state latched the frame stops after x and the prior h_prev is reused
        frame_end = accept & seg_end & ((seg == SEG_H) | ((seg == SEG_X) & keep_q));
        capture   = (state == WAIT) & core_done;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end
    always_comb begin
        state_n    = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        busy       = 1'b1;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (frame_end) state_n = FIRE;
            end
            FIRE: begin
                core_start = 1'b1;
                state_n    = WAIT;
            end
            WAIT:    if (core_done) state_n = DRAIN;
            default: if (drain_done) state_n = LOAD;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            seg         <= SEG_DT;
            idx         <= '0;
            keep_q      <= 1'b0;
            dt_flat     <= '0;
            dA_flat     <= '0;
            Bmat_flat   <= '0;
            C_flat      <= '0;
            D_flat      <= '0;
            x_flat      <= '0;
            h_prev_flat <= '0;
        end else if (accept) begin
            if (seg == SEG_DT && idx == '0) keep_q <= keep_state;
            case (seg)
                SEG_DT:  dt_flat[DW*idx +: DW]     <= in_data;
                SEG_DA:  dA_flat[DW*idx +: DW]     <= in_data;
                SEG_BM:  Bmat_flat[DW*idx +: DW]   <= in_data;
                SEG_C:   C_flat[DW*idx +: DW]      <= in_data;
                SEG_D:   D_flat[DW*idx +: DW]      <= in_data;
                SEG_X:   x_flat[DW*idx +: DW]      <= in_data;
                default: h_prev_flat[DW*idx +: DW] <= in_data;
            endcase
            if (seg_end) begin
                idx <= '0;
                seg <= frame_end ? SEG_DT : seg_t'(seg + 1'b1);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
    ssm_word_serializer #(.WORDS(B*H*P), .DW(DW)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (capture),
        .y_in      (core_y_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (drain_done)
    );
endmodule
